arm_lsu: RTL and testbench

Parametrised load/store unit between the pipelined ARM datapath's memory stage and data memory. It replaces fixed byte-enable generation with byte, halfword and word (and doubleword at DATA_W=64) accesses. It adds little-endian lane steering, sign/zero extension on loads, and memory wait states via a valid/ready handshake. Misaligned accesses that cross a bus word are either split into two memory beats or flagged as errors.

---
 rtl/arm_lsu.sv | 183 ++++++++++++++++++
 tb/tb_arm_lsu.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/arm_lsu.sv
// Load/store unit: byte/half/word/dword accesses with little-endian lane steering,
// load extension, optional two-beat split of bus-word-crossing accesses, valid/ready waits.
module arm_lsu #(
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned ADDR_W      = 32,
  parameter bit          ALIGN_SPLIT = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [1:0]        req_size,
  input  logic              req_signed,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_err,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W/8-1:0] mem_be,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ready,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int          NB  = DATA_W / 8;
  localparam int          OW  = $clog2(NB);
  localparam logic [4:0]  NB5 = 5'(NB);

  typedef enum logic [1:0] {StIdle, StBeat0, StBeat1, StResp} state_e;

  state_e              state_q, state_d;
  logic                write_q, write_d;
  logic                signed_q, signed_d;
  logic                err_q, err_d;
  logic [1:0]          size_q, size_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [2*DATA_W-1:0] raw_q, raw_d;

  // Request decode for the legality check at accept time.
  logic [OW-1:0] req_off;
  logic [4:0]    req_sz, req_end;
  logic          req_illegal;

  assign req_off     = req_addr[OW-1:0];
  assign req_sz      = 5'd1 << req_size;
  assign req_end     = 5'(req_off) + req_sz;
  assign req_illegal = (req_sz > NB5) || (!ALIGN_SPLIT && (req_end > NB5));

  // Latched access geometry.
  logic [OW-1:0]       off_q;
  logic [4:0]          sz_q, end_q;
  logic                crosses;
  logic [2*NB-1:0]     span;
  logic [2*DATA_W-1:0] span_bits;
  logic [2*DATA_W-1:0] wide_w;
  logic [ADDR_W-1:0]   base;

  assign off_q   = addr_q[OW-1:0];
  assign sz_q    = 5'd1 << size_q;
  assign end_q   = 5'(off_q) + sz_q;
  assign crosses = end_q > NB5;
  // Lanes touched across both beats: low half is beat 0, high half is beat 1.
  assign span    = ~({2*NB{1'b1}} << sz_q) << off_q;
  assign wide_w  = {{DATA_W{1'b0}}, wdata_q} << {off_q, 3'b000};
  assign base    = {addr_q[ADDR_W-1:OW], {OW{1'b0}}};

  always_comb begin
    span_bits = '0;
    for (int i = 0; i < 2 * NB; i++) begin
      span_bits[8*i +: 8] = {8{span[i]}};
    end
  end

  // Load assembly: collected lanes shifted down to byte 0, then extended.
  logic [2*DATA_W-1:0] raw_sh;
  logic [DATA_W-1:0]   asm_data, ext_data;
  logic                sign_bit;

  always_comb begin
    raw_sh   = raw_q >> {off_q, 3'b000};
    asm_data = raw_sh[DATA_W-1:0];
    sign_bit = 1'b0;
    for (int b = 0; b < NB; b++) begin
      if (sz_q == 5'(b + 1)) sign_bit = asm_data[8*b+7];
    end
    ext_data = asm_data;
    for (int b = 0; b < NB; b++) begin
      if (5'(b) >= sz_q) ext_data[8*b +: 8] = {8{sign_bit & signed_q}};
    end
  end

  always_comb begin
    state_d    = state_q;
    write_d    = write_q;
    signed_d   = signed_q;
    err_d      = err_q;
    size_d     = size_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    raw_d      = raw_q;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    resp_err   = 1'b0;
    resp_rdata = '0;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    mem_addr   = '0;
    mem_be     = '0;
    mem_wdata  = '0;
    unique case (state_q)
      StIdle: begin
        req_ready = !reset;
        if (req_valid) begin
          write_d  = req_write;
          signed_d = req_signed;
          size_d   = req_size;
          addr_d   = req_addr;
          wdata_d  = req_wdata;
          err_d    = req_illegal;
          raw_d    = '0;
          state_d  = req_illegal ? StResp : StBeat0;
        end
      end
      StBeat0: begin
        mem_req   = 1'b1;
        mem_we    = write_q;
        mem_addr  = base;
        mem_be    = span[NB-1:0];
        mem_wdata = wide_w[DATA_W-1:0];
        if (mem_ready) begin
          if (!write_q) raw_d[DATA_W-1:0] = mem_rdata & span_bits[DATA_W-1:0];
          state_d = crosses ? StBeat1 : StResp;
        end
      end
      StBeat1: begin
        mem_req   = 1'b1;
        mem_we    = write_q;
        mem_addr  = base + ADDR_W'(NB);
        mem_be    = span[2*NB-1:NB];
        mem_wdata = wide_w[2*DATA_W-1:DATA_W];
        if (mem_ready) begin
          if (!write_q) raw_d[2*DATA_W-1:DATA_W] = mem_rdata & span_bits[2*DATA_W-1:DATA_W];
          state_d = StResp;
        end
      end
      StResp: begin
        resp_valid = 1'b1;
        resp_err   = err_q;
        resp_rdata = (write_q || err_q) ? '0 : ext_data;
        state_d    = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= StIdle;
      write_q  <= 1'b0;
      signed_q <= 1'b0;
      err_q    <= 1'b0;
      size_q   <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      raw_q    <= '0;
    end else begin
      state_q  <= state_d;
      write_q  <= write_d;
      signed_q <= signed_d;
      err_q    <= err_d;
      size_q   <= size_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      raw_q    <= raw_d;
    end
  end

endmodule

// File: tb/tb_arm_lsu.sv
// Bench for arm_lsu (DATA_W=32): directed plan steps plus random accesses checked against
// a byte-level reference model; a second instance with ALIGN_SPLIT=0 covers rejection.
module tb_arm_lsu;

  localparam int NB = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_valid_ns;
  logic        req_write, req_signed;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic        mem_ready;
  logic [31:0] mem_rdata;

  logic        req_ready, resp_valid, resp_err, mem_req, mem_we;
  logic [31:0] resp_rdata, mem_addr, mem_wdata;
  logic [3:0]  mem_be;

  logic        req_ready_ns, resp_valid_ns, resp_err_ns, mem_req_ns, mem_we_ns;
  logic [31:0] resp_rdata_ns, mem_addr_ns, mem_wdata_ns;
  logic [3:0]  mem_be_ns;
  logic        ns_req_seen = 1'b0;

  int unsigned vectors = 0;
  int unsigned miscompares = 0;

  always #5 clk = ~clk;

  arm_lsu #(.DATA_W(32), .ADDR_W(32), .ALIGN_SPLIT(1'b1)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
    .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .resp_err(resp_err), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_be(mem_be), .mem_wdata(mem_wdata), .mem_ready(mem_ready), .mem_rdata(mem_rdata)
  );

  arm_lsu #(.DATA_W(32), .ADDR_W(32), .ALIGN_SPLIT(1'b0)) dut_ns (
    .clk(clk), .reset(reset),
    .req_valid(req_valid_ns), .req_ready(req_ready_ns), .req_write(req_write),
    .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
    .req_wdata(req_wdata), .resp_valid(resp_valid_ns), .resp_rdata(resp_rdata_ns),
    .resp_err(resp_err_ns), .mem_req(mem_req_ns), .mem_we(mem_we_ns),
    .mem_addr(mem_addr_ns), .mem_be(mem_be_ns), .mem_wdata(mem_wdata_ns),
    .mem_ready(mem_ready), .mem_rdata(mem_rdata)
  );

  always @(posedge clk) if (mem_req_ns) ns_req_seen <= 1'b1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One access on the split instance; memory answers beat b with rd0/rd1 after
  // 'waits' stall cycles (negative = random 0..2).
  task automatic access(input logic w, input logic [1:0] size, input logic sgn,
                        input logic [31:0] addr, input logic [31:0] wd,
                        input logic [31:0] rd0, input logic [31:0] rd1, input int waits);
    int               sz, off, nbeats, wt, lane;
    logic [3:0]       be0, be1, bbe;
    logic [31:0]      baddr, bwd;
    logic [7:0]       byt;
    longint unsigned  exp_rd;
    sz     = 1 << size;
    off    = int'(addr % NB);
    be0    = '0;
    be1    = '0;
    exp_rd = 0;
    if (sz <= NB) begin
      for (int i = 0; i < sz; i++) begin
        lane = off + i;
        if (lane < NB) begin
          be0[lane] = 1'b1;
          byt = rd0[8*lane +: 8];
        end else begin
          be1[lane-NB] = 1'b1;
          byt = rd1[8*(lane-NB) +: 8];
        end
        exp_rd = exp_rd | (longint'(byt) << (8 * i));
      end
      if (sgn && exp_rd[8*sz-1]) exp_rd = exp_rd | ~((64'd1 << (8 * sz)) - 64'd1);
    end
    exp_rd = exp_rd & 64'hFFFF_FFFF;
    if (w) exp_rd = 0;
    nbeats = (off + sz > NB) ? 2 : 1;

    chk("req_ready_idle", req_ready, 1);
    req_valid  = 1'b1;
    req_write  = w;
    req_size   = size;
    req_signed = sgn;
    req_addr   = addr;
    req_wdata  = wd;
    tick();
    req_valid = 1'b0;

    if (sz > NB) begin
      chk("err_resp_valid", resp_valid, 1);
      chk("err_resp_err", resp_err, 1);
      chk("err_mem_req", mem_req, 0);
      chk("err_rdata", resp_rdata, 0);
      tick();
      chk("err_resp_pulse", resp_valid, 0);
      return;
    end

    for (int b = 0; b < nbeats; b++) begin
      baddr = (addr & ~32'd3) + ((b == 1) ? 32'd4 : 32'd0);
      bbe   = (b == 1) ? be1 : be0;
      bwd   = (b == 1) ? (wd >> (8 * (NB - off))) : (wd << (8 * off));
      wt    = (waits < 0) ? int'($urandom_range(0, 2)) : waits;
      for (int k = 0; k <= wt; k++) begin
        chk("mem_req", mem_req, 1);
        chk("mem_addr", mem_addr, baddr);
        chk("mem_be", mem_be, bbe);
        chk("mem_we", mem_we, w);
        if (w) chk("mem_wdata", mem_wdata, bwd);
        chk("req_ready_busy", req_ready, 0);
        chk("resp_valid_busy", resp_valid, 0);
        mem_ready = (k == wt);
        mem_rdata = (k == wt) ? ((b == 1) ? rd1 : rd0) : $urandom();
        tick();
        mem_ready = 1'b0;
      end
    end
    chk("resp_valid", resp_valid, 1);
    chk("resp_err", resp_err, 0);
    chk("resp_rdata", resp_rdata, exp_rd);
    chk("mem_req_resp", mem_req, 0);
    chk("req_ready_resp", req_ready, 0);
    tick();
    chk("resp_pulse", resp_valid, 0);
  endtask

  initial begin
    reset        = 1'b1;
    req_valid    = 1'b0;
    req_valid_ns = 1'b0;
    req_write    = 1'b0;
    req_size     = 2'd0;
    req_signed   = 1'b0;
    req_addr     = '0;
    req_wdata    = '0;
    mem_ready    = 1'b0;
    mem_rdata    = '0;
    tick();
    chk("rst_req_ready", req_ready, 0);
    chk("rst_mem_req", mem_req, 0);
    chk("rst_resp_valid", resp_valid, 0);
    chk("rst_mem_be", mem_be, 0);
    tick();
    reset = 1'b0;
    #1;
    chk("rst_release_ready", req_ready, 1);
    tick();

    // Word store, byte loads signed/unsigned, split half store, split word load.
    access(1'b1, 2'd2, 1'b0, 32'h100, 32'hDEAD_BEEF, 32'h0, 32'h0, 0);
    access(1'b0, 2'd0, 1'b1, 32'h103, 32'h0, 32'h8012_3456, 32'h0, 0);
    access(1'b0, 2'd0, 1'b0, 32'h103, 32'h0, 32'h8012_3456, 32'h0, 0);
    access(1'b1, 2'd1, 1'b0, 32'h203, 32'h0000_ABCD, 32'h0, 32'h0, 0);
    access(1'b0, 2'd2, 1'b0, 32'h302, 32'h0, 32'h1122_AAAA, 32'hBBBB_3344, 0);
    // Wait states, signed half load, doubleword rejected at 32 bits.
    access(1'b0, 2'd2, 1'b0, 32'h400, 32'h0, 32'hCAFE_F00D, 32'h0, 3);
    access(1'b0, 2'd1, 1'b1, 32'h502, 32'h0, 32'h9ABC_0000, 32'h0, 1);
    access(1'b0, 2'd3, 1'b1, 32'h500, 32'h0, 32'h0, 32'h0, 0);
    access(1'b1, 2'd0, 1'b1, 32'h601, 32'h0000_00F7, 32'h0, 32'h0, 0);

    // Rejection without split on the second instance.
    req_write    = 1'b1;
    req_size     = 2'd1;
    req_signed   = 1'b0;
    req_addr     = 32'h203;
    req_wdata    = 32'h0000_ABCD;
    chk("ns_req_ready", req_ready_ns, 1);
    req_valid_ns = 1'b1;
    tick();
    req_valid_ns = 1'b0;
    chk("ns_resp_valid", resp_valid_ns, 1);
    chk("ns_resp_err", resp_err_ns, 1);
    chk("ns_rdata", resp_rdata_ns, 0);
    chk("ns_mem_req", mem_req_ns, 0);
    tick();
    chk("ns_resp_pulse", resp_valid_ns, 0);
    chk("ns_req_ready_back", req_ready_ns, 1);

    // Reset during the second beat of a split load.
    req_write  = 1'b0;
    req_size   = 2'd2;
    req_addr   = 32'h302;
    req_valid  = 1'b1;
    tick();
    req_valid = 1'b0;
    mem_ready = 1'b1;
    mem_rdata = 32'h1122_AAAA;
    tick();
    mem_ready = 1'b0;
    chk("r6_beat1_addr", mem_addr, 32'h304);
    chk("r6_beat1_be", mem_be, 4'b0011);
    reset = 1'b1;
    tick();
    chk("r6_mem_req_drop", mem_req, 0);
    chk("r6_no_resp", resp_valid, 0);
    chk("r6_ready_in_reset", req_ready, 0);
    reset = 1'b0;
    #1;
    chk("r6_ready_after", req_ready, 1);
    tick();
    chk("r6_no_resp_after", resp_valid, 0);
    access(1'b1, 2'd0, 1'b0, 32'h777, 32'h0000_005A, 32'h0, 32'h0, 0);

    // Random accesses, including illegal doublewords.
    for (int n = 0; n < 200; n++) begin
      access(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
             $urandom(), $urandom(), $urandom(), $urandom(), -1);
    end

    chk("ns_never_requested", ns_req_seen, 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
